// File: rtl/hs_arb_pkg.sv
// Shared types and defaults for the handshake round-robin arbiter.
//   state_t    : output-register occupancy (EMPTY / FULL)
//   N_REQ_DEF  : default requester count
//   DATA_W_DEF : default payload width
package hs_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/hs_rr_picker.sv
// Round-robin grant search: first set bit of req, starting at rr_ptr and
// wrapping from N_REQ-1 back to 0. Purely combinational.
//   req     : request vector (one bit per requester)
//   rr_ptr  : search start index
//   gnt_vld : some request is set
//   gnt_idx : winning requester index (0 when gnt_vld=0)
module hs_rr_picker
  import hs_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SW-1:0]    rr_ptr,
  output logic             gnt_vld,
  output logic [SW-1:0]    gnt_idx
);

  // Scan offsets from the far end down so the nearest offset from rr_ptr
  // is the last assignment and therefore wins.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// N_REQ-way valid/ready round-robin arbiter feeding a single registered
// output beat. Full throughput: a held beat can be replaced in the same
// cycle it is consumed.
//   clk          : clock, rising edge
//   rst_n        : asynchronous reset, active HIGH (legacy name)
//   in_valid_i   : per-requester valid
//   in_data_i    : per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   in_ready_o   : per-requester ready, one-hot or zero
//   out_valid_o  : registered downstream valid
//   out_data_o   : registered downstream payload
//   out_src_o    : requester index that sourced out_data_o
//   out_ready_i  : downstream ready
// Build option: define HS_ARB_HIPRI_EN to give requester 0 absolute
// priority; its wins leave the round-robin pointer untouched.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          in_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   in_data_i,
  output logic [N_REQ-1:0]          in_ready_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic [$clog2(N_REQ)-1:0]  out_src_o,
  input  logic                      out_ready_i
);

  localparam int SW = $clog2(N_REQ);

  state_t                       state, state_nxt;
  logic [SW-1:0]                rr_ptr, pick_idx, gnt_idx;
  logic                         pick_vld, gnt_vld, can_accept, xfer, ptr_adv;
  logic [N_REQ-1:0][DATA_W-1:0] data_arr;

  assign data_arr = in_data_i;

  hs_rr_picker #(.N_REQ(N_REQ), .SW(SW)) u_picker (
    .req     (in_valid_i),
    .rr_ptr  (rr_ptr),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  assign gnt_vld = pick_vld;
`ifdef HS_ARB_HIPRI_EN
  assign gnt_idx = in_valid_i[0] ? '0 : pick_idx;
  assign ptr_adv = xfer && !in_valid_i[0];
`else
  assign gnt_idx = pick_idx;
  assign ptr_adv = xfer;
`endif

  // in_ready is combinational, so reset must gate it explicitly: the
  // registers alone would leave EMPTY advertising readiness during reset.
  assign can_accept = !rst_n && ((state == EMPTY) || out_ready_i);
  assign xfer       = gnt_vld && can_accept;
  assign in_ready_o = xfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign out_valid_o = (state == FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (out_ready_i && !xfer) state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= EMPTY;
      out_data_o <= '0;
      out_src_o  <= '0;
      rr_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        out_data_o <= data_arr[gnt_idx];
        out_src_o  <= gnt_idx;
      end
      if (ptr_adv)
        rr_ptr <= (gnt_idx == SW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Self-checking bench for hs_rr_arbiter (N_REQ=4, DATA_W=8).
// A reference model predicts grants; accepted beats are pushed onto a
// scoreboard queue and popped when the DUT presents and hands them off.
module tb_hs_rr_arbiter;

  typedef struct {
    int         src;
    logic [7:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      in_valid_i;
  logic [3:0][7:0] dat;
  logic [31:0]     in_data_i;
  logic [3:0]      in_ready_o;
  logic            out_valid_o;
  logic [7:0]      out_data_o;
  logic [1:0]      out_src_o;
  logic            out_ready_i;

  assign in_data_i = dat;

  hs_rr_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_err = 0;
  beat_t q[$];
  beat_t seen[$];
  int    ptr = 0;
  int    acc_g;
  bit    seq_en = 1'b0;
  int    exp_seq[4];
  int    seed = 7;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v);
`ifdef HS_ARB_HIPRI_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Called at a negedge: drive, check against the model, advance the model,
  // then run one clock and return at the next negedge.
  task automatic step(input logic [3:0] v, input logic r);
    logic [3:0] rdy;
    int         g;
    bit         full;
    in_valid_i  = v;
    out_ready_i = r;
    #1;
    full  = (q.size() != 0);
    g     = pick(v);
    rdy   = '0;
    acc_g = -1;
    if (g >= 0 && (!full || r)) rdy[g] = 1'b1;
    chk("in_ready", in_ready_o, rdy);
    chk("out_valid", out_valid_o, full);
    if (full) begin
      chk("out_data", out_data_o, q[0].data);
      chk("out_src", out_src_o, q[0].src);
      if (r) begin
        if (seq_en) begin
          chk("seq", out_data_o, exp_seq[q[0].src]);
          exp_seq[q[0].src]++;
        end
        seen.push_back(q[0]);
        void'(q.pop_front());
      end
    end
    if (rdy != 0) begin
      q.push_back('{src: g, data: dat[g]});
      acc_g = g;
`ifdef HS_ARB_HIPRI_EN
      if (!v[0]) ptr = (g + 1) % 4;
`else
      ptr = (g + 1) % 4;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b1;
    in_valid_i  = 4'hF;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);

    // Reset held 5 cycles, requests pending: nothing may be granted.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_out_data", out_data_o, 0);
      chk("rst_out_src", out_src_o, 0);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Full-rate rotation with all requesters valid.
    seen.delete();
    for (int c = 0; c < 8; c++) step(4'hF, 1'b1);
    step(4'b0000, 1'b1);
    chk("rot_count", seen.size(), 8);
    for (int k = 0; k < 8 && k < seen.size(); k++) begin
      chk("rot_src", seen[k].src, k % 4);
      chk("rot_data", seen[k].data, 8'h10 + k % 4);
    end

    // Back-pressure hold, then replace in the same cycle with no bubble.
    step(4'b0001, 1'b0);
    for (int c = 0; c < 3; c++) step(4'hF, 1'b0);
    step(4'b0100, 1'b1);
    chk("nobubble_valid", out_valid_o, 1);
    chk("nobubble_src", out_src_o, 2);

    // Drive ptr to 2 while holding a beat, then reset mid-transfer.
    for (int c = 0; c < 3; c++) step(4'hF, 1'b1);
    step(4'b0000, 1'b0);
    chk("pre_rst_ptr", ptr, 2);
    chk("pre_rst_full", out_valid_o, 1);
    rst_n = 1'b1;
    #1;
    chk("rst_async_valid", out_valid_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    ptr = 0;
    in_valid_i = 4'hF;
    #1;
    chk("rst_first_gnt", in_ready_o, 4'b0001);
    step(4'hF, 1'b1);
    step(4'b0000, 1'b1);

`ifdef HS_ARB_HIPRI_EN
    // Requester 0 dominates, then rotation continues from the saved pointer.
    seen.delete();
    for (int c = 0; c < 5; c++) step(4'hF, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b1110, 1'b1);
    step(4'b0000, 1'b1);
    chk("hip_count", seen.size(), 8);
    for (int k = 0; k < 8 && k < seen.size(); k++)
      chk("hip_src", seen[k].src, (k < 5) ? 0 : k - 4);
`endif

    // Random traffic: each requester sends 1..10; per-source order checked.
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      dat[i]     = 8'd1;
      exp_seq[i] = 1;
    end
    seq_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] v;
      int         rv, rr;
      for (int i = 0; i < 4; i++) begin
        rv   = $random(seed);
        v[i] = (dat[i] <= 8'd10) && rv[0];
      end
      rr = $random(seed);
      step(v, rr[1] | rr[0]);
      if (acc_g >= 0) dat[acc_g] = dat[acc_g] + 8'd1;
      if (dat == {4{8'd11}} && q.size() == 0) break;
    end
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("rand_sent", dat[i], 11);
      chk("rand_recv", exp_seq[i], 11);
    end
    chk("rand_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
